result_storer_layer1_1: RTL

Writes a layer-1 output vector of `OUT_SIZE` packed `W`-bit words into the shared BRAM. Words go to consecutive addresses from `BASE_ADDR`, so a matching loader can later fetch them with the same packing. It sits after the layer-1 neuron array and before the next layer's loader. An optional read-back verify pass checks every stored word and reports mismatches.

---
 rtl/result_storer_layer1_1_pkg.sv | 15 +
 rtl/result_storer_layer1_1_bram.sv | 22 ++
 rtl/result_storer_layer1_1.sv | 132 +++++++++++++
 3 files changed

// File: rtl/result_storer_layer1_1_pkg.sv
// Shared definitions for layer-1 result storers and the loaders that read the same buffers.
package result_storer_layer1_1_pkg;
  localparam int BRAM_W          = 8;
  localparam int BRAM_ADDR_WIDTH = 18;

  // Layer-1 output buffer base; loaders for layer 2 fetch from the same address.
  localparam int L1_OUT_BASE = 149504;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } rs_state_t;
endpackage

// File: rtl/result_storer_layer1_1_bram.sv
// Single-port BRAM, read data valid two cycles after the address is presented.
module result_storer_layer1_1_bram #(
  parameter int W  = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          en,
  input  logic          ren,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (en && wen) mem[addr] <= din;
    if (en && ren) r_rd <= mem[addr];
    dout <= r_rd;
  end
endmodule

// File: rtl/result_storer_layer1_1.sv
// Stores a captured layer-1 output vector into BRAM word by word, then optionally reads it back to verify.
module result_storer_layer1_1
  import result_storer_layer1_1_pkg::*;
#(
  parameter int OUT_SIZE    = 8,
  parameter int W           = BRAM_W,
  parameter int TOTAL_WORDS = OUT_SIZE,
  parameter int ADDR_WIDTH  = BRAM_ADDR_WIDTH,
  parameter int BASE_ADDR   = L1_OUT_BASE,
  parameter bit VERIFY_EN   = 1'b1,
  localparam int CW         = $clog2(TOTAL_WORDS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [TOTAL_WORDS*W-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     verify_err,
  output logic [CW-1:0]            err_count
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0] N_C  = CW'(TOTAL_WORDS);
  localparam logic [CW-1:0] LAST = CW'(TOTAL_WORDS - 1);

  rs_state_t                r_state;
  logic [TOTAL_WORDS*W-1:0] r_data;
  logic [CW-1:0]            r_idx, r_cmp, r_err_cnt;
  logic [1:0]               r_vld_pipe;
  logic                     r_en, r_wen, r_ren, r_busy, r_done, r_err;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [W-1:0]             r_din;
  logic [W-1:0]             w_dout, w_word, w_cword;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic                     w_accept;

  assign w_accept = start && !r_busy && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_word   = r_data[r_idx*W +: W];
  assign w_cword  = r_data[r_cmp*W +: W];
  assign w_addr   = BASE + ADDR_WIDTH'(r_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cmp      <= '0;
      r_err_cnt  <= '0;
      r_vld_pipe <= '0;
      r_en       <= 1'b0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Compare valid trails the read strobe by the BRAM's two-cycle latency.
      r_vld_pipe <= {r_vld_pipe[0], r_en & r_ren};
      if (w_accept) begin
        r_data    <= data_in;
        r_idx     <= '0;
        r_cmp     <= '0;
        r_err_cnt <= '0;
        r_err     <= 1'b0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_state   <= ST_WRITE;
      end else begin
        case (r_state)
          ST_WRITE: begin
            if (r_idx != N_C) begin
              r_en   <= 1'b1;
              r_wen  <= 1'b1;
              r_ren  <= 1'b0;
              r_addr <= w_addr;
              r_din  <= w_word;
              if (VERIFY_EN && r_idx == LAST) begin
                r_idx   <= '0;
                r_state <= ST_VERIFY;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_en    <= 1'b0;
              r_wen   <= 1'b0;
              r_state <= ST_DONE;
            end
          end
          ST_VERIFY: begin
            if (r_idx != N_C) begin
              r_en   <= 1'b1;
              r_wen  <= 1'b0;
              r_ren  <= 1'b1;
              r_addr <= w_addr;
              r_idx  <= r_idx + 1'b1;
            end else begin
              r_en  <= 1'b0;
              r_ren <= 1'b0;
            end
            if (r_vld_pipe[1]) begin
              if (w_dout != w_cword) begin
                r_err <= 1'b1;
                if (r_err_cnt != N_C) r_err_cnt <= r_err_cnt + 1'b1;
              end
              r_cmp <= r_cmp + 1'b1;
              if (r_cmp == LAST) r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  result_storer_layer1_1_bram #(.W(W), .AW(ADDR_WIDTH)) u_bram (
    .clk  (clk),
    .en   (r_en),
    .ren  (r_ren),
    .wen  (r_wen),
    .addr (r_addr),
    .din  (r_din),
    .dout (w_dout)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign verify_err = r_err;
  assign err_count  = r_err_cnt;
endmodule
